// File: rtl/gates_reduce_seq_if.sv
// Stream bundle for gates_reduce_seq: word input, frame-result output and status.
// Optional ones_words field is present when GATES_REDUCE_SEQ_ONES_CNT_EN is defined.
interface gates_reduce_seq_if #(
  parameter int WIDTH = 100,
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] in_;
  logic             in_valid;
  logic             in_ready;
  logic             out_and;
  logic             out_or;
  logic             out_xor;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
`ifdef GATES_REDUCE_SEQ_ONES_CNT_EN
  logic [LEN_W-1:0] ones_words;

  modport master (
    output start, len, in_, in_valid, out_ready,
    input  in_ready, out_and, out_or, out_xor, out_valid, busy, ones_words
  );
  modport slave (
    input  start, len, in_, in_valid, out_ready,
    output in_ready, out_and, out_or, out_xor, out_valid, busy, ones_words
  );
`else
  modport master (
    output start, len, in_, in_valid, out_ready,
    input  in_ready, out_and, out_or, out_xor, out_valid, busy
  );
  modport slave (
    input  start, len, in_, in_valid, out_ready,
    output in_ready, out_and, out_or, out_xor, out_valid, busy
  );
`endif
endinterface

// File: rtl/gates_reduce_seq.sv
// Frame sequencer folding LEN words into AND/OR/XOR reductions, one frame in flight.
// Optional all-ones word counter enabled by GATES_REDUCE_SEQ_ONES_CNT_EN.
module gates_reduce_seq #(
  parameter int WIDTH = 100,
  parameter int LEN_W = 8
) (
  input logic               clk,
  input logic               rst,
  gates_reduce_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  function automatic logic f_all_ones(input logic [WIDTH-1:0] d);
    return &d;
  endfunction

  function automatic logic f_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  state_t           r_state;
  logic [LEN_W-1:0] r_rem;
  logic             r_and;
  logic             r_or;
  logic             r_xor;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
`ifdef GATES_REDUCE_SEQ_ONES_CNT_EN
  logic [LEN_W-1:0] r_ones_words;
`endif

  logic w_accept;
  logic w_word_ones;
  logic w_word_any;
  logic w_word_par;

  assign w_accept    = bus.in_valid & r_in_ready;
  assign w_word_ones = f_all_ones(bus.in_);
  assign w_word_any  = |bus.in_;
  assign w_word_par  = f_parity(bus.in_);

  // Sequencer state, accumulators and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_and       <= 1'b1;
      r_or        <= 1'b0;
      r_xor       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef GATES_REDUCE_SEQ_ONES_CNT_EN
      r_ones_words <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_rem  <= bus.len;
            r_and  <= 1'b1;
            r_or   <= 1'b0;
            r_xor  <= 1'b0;
            r_busy <= 1'b1;
`ifdef GATES_REDUCE_SEQ_ONES_CNT_EN
            r_ones_words <= '0;
`endif
            if (bus.len != '0) begin
              r_state    <= ST_ACCUM;
              r_in_ready <= 1'b1;
            end else begin
              // Empty frame reports identity results straight away
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_and <= r_and & w_word_ones;
            r_or  <= r_or | w_word_any;
            r_xor <= r_xor ^ w_word_par;
            r_rem <= r_rem - LEN_ONE;
`ifdef GATES_REDUCE_SEQ_ONES_CNT_EN
            if (w_word_ones) begin
              r_ones_words <= r_ones_words + LEN_ONE;
            end
`endif
            if (r_rem == LEN_ONE) begin
              r_state     <= ST_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.out_and   = r_and;
  assign bus.out_or    = r_or;
  assign bus.out_xor   = r_xor;
`ifdef GATES_REDUCE_SEQ_ONES_CNT_EN
  assign bus.ones_words = r_ones_words;
`endif

endmodule
